// File: rtl/emio_led_ctrl.sv
// emio_led_ctrl: arbitrates board LEDs/buttons between local logic and the PS7 EMIO GPIO bank.
// Optional PWM dimming of PS-driven LEDs is built when EMIO_LED_PWM_EN is defined.
module emio_led_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLINK_DIV       = 24,
    parameter int unsigned HB_TIMEOUT      = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  btn,
    output logic [3:0]  led,
    input  logic [63:0] emio_gpio_o,
    input  logic [63:0] emio_gpio_t,
    output logic [63:0] emio_gpio_i,
    output logic        ps_owner
);

    localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int HB_W = ($clog2(HB_TIMEOUT) < 1) ? 1 : $clog2(HB_TIMEOUT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_LOCAL   = 2'd0,
        ST_PS      = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    logic [63:0] q;
    logic [3:0]  q_led;
    logic [3:0]  q_ack;
    logic        q_hb;
    logic        q_req;

    logic [3:0]            btn_meta_p0;
    logic [3:0]            btn_sync_p1;
    logic [3:0]            btn_last_p2;
    logic [3:0][DB_W-1:0]  db_cnt;
    logic [3:0][DB_W-1:0]  db_cnt_nxt;
    logic [3:0]            btn_deb;
    logic [3:0]            btn_deb_nxt;

    logic [3:0] ack_prev;
    logic [3:0] ack_rise;
    logic [3:0] deb_rise;
    logic [3:0] evt;
    logic [3:0] evt_nxt;

    state_t          state;
    state_t          state_nxt;
    logic [HB_W-1:0] hb_cnt;
    logic [HB_W-1:0] hb_cnt_nxt;
    logic            hb_prev;
    logic            hb_change;
    logic            to_flag;
    logic            to_flag_nxt;

    logic [BLINK_DIV-1:0] blink_cnt;
    logic                 blink_wrap;
    logic [3:0]           walker;
    logic                 lock_phase;

    logic [3:0] ps_led;
    logic [3:0] led_nxt;

    // A PS bit only counts when the PS is actually driving it.
    assign q     = emio_gpio_o & ~emio_gpio_t;
    assign q_led = q[3:0];
    assign q_ack = q[11:8];
    assign q_hb  = q[62];
    assign q_req = q[63];

`ifdef EMIO_LED_PWM_EN
    logic [7:0] pwm_cnt;
    logic       pwm_on;
    logic       unused_q;

    assign pwm_on   = (pwm_cnt < q[23:16]);
    assign ps_led   = q_led & {4{pwm_on}};
    assign unused_q = ^{q[61:24], q[15:12], q[7:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end
`else
    logic unused_q;

    assign ps_led   = q_led;
    assign unused_q = ^{q[61:12], q[7:4]};
`endif

    // Synchroniser stages and per-bit stability counters.
    always_comb begin
        btn_deb_nxt = btn_deb;
        db_cnt_nxt  = db_cnt;
        for (int b = 0; b < 4; b++) begin
            if (btn_sync_p1[b] != btn_last_p2[b]) begin
                db_cnt_nxt[b] = '0;
            end else if (db_cnt[b] == DB_LAST) begin
                btn_deb_nxt[b] = btn_sync_p1[b];
            end else begin
                db_cnt_nxt[b] = db_cnt[b] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_p0 <= '0;
            btn_sync_p1 <= '0;
            btn_last_p2 <= '0;
            db_cnt      <= '0;
            btn_deb     <= '0;
        end else begin
            btn_meta_p0 <= btn;
            btn_sync_p1 <= btn_meta_p0;
            btn_last_p2 <= btn_sync_p1;
            db_cnt      <= db_cnt_nxt;
            btn_deb     <= btn_deb_nxt;
        end
    end

    // Sticky press events; a new press beats a simultaneous acknowledge.
    assign ack_rise = q_ack & ~ack_prev;
    assign deb_rise = btn_deb_nxt & ~btn_deb;
    assign evt_nxt  = (evt & ~ack_rise) | deb_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_prev <= '0;
            evt      <= '0;
        end else begin
            ack_prev <= q_ack;
            evt      <= evt_nxt;
        end
    end

    assign hb_change = q_hb ^ hb_prev;

    always_comb begin
        state_nxt   = state;
        hb_cnt_nxt  = hb_cnt;
        to_flag_nxt = to_flag;
        case (state)
            ST_LOCAL: begin
                if (q_req) begin
                    state_nxt  = ST_PS;
                    hb_cnt_nxt = '0;
                end
            end
            ST_PS: begin
                if (!q_req) begin
                    state_nxt = ST_LOCAL;
                end else if (hb_change) begin
                    hb_cnt_nxt = '0;
                end else if (hb_cnt == HB_LAST) begin
                    state_nxt   = ST_LOCKOUT;
                    to_flag_nxt = 1'b1;
                end else begin
                    hb_cnt_nxt = hb_cnt + HB_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (!q_req) begin
                    state_nxt   = ST_LOCAL;
                    to_flag_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt   = ST_LOCAL;
                to_flag_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOCAL;
            hb_cnt  <= '0;
            hb_prev <= 1'b0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            hb_cnt  <= hb_cnt_nxt;
            hb_prev <= q_hb;
            to_flag <= to_flag_nxt;
        end
    end

    // Free-running blink timebase drives both the walker and the lockout flash.
    assign blink_wrap = &blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt  <= '0;
            walker     <= 4'b0001;
            lock_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_DIV'(1);
            if (blink_wrap) begin
                walker     <= {walker[2:0], walker[3]};
                lock_phase <= ~lock_phase;
            end
        end
    end

    always_comb begin
        led_nxt = 4'b0000;
        case (state)
            ST_LOCAL:   led_nxt = walker ^ btn_deb;
            ST_PS:      led_nxt = ps_led;
            ST_LOCKOUT: led_nxt = lock_phase ? 4'b0101 : 4'b1010;
            default:    led_nxt = 4'b0000;
        endcase
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led         <= '0;
            emio_gpio_i <= '0;
        end else begin
            led         <= led_nxt;
            emio_gpio_i <= {54'd0, to_flag, (state == ST_PS), evt, btn_deb};
        end
    end

    assign ps_owner = (state == ST_PS);

endmodule

// File: tb/tb_emio_led_ctrl.sv
// tb_emio_led_ctrl: directed and randomized stimulus for emio_led_ctrl, checked every cycle
// against a behavioural reference model; EMIO_LED_PWM_EN selects the PWM duty scenario.
module tb_emio_led_ctrl;

    localparam int DEB  = 4;
    localparam int BDIV = 3;
    localparam int HBT  = 16;

    localparam int M_LOCAL = 0;
    localparam int M_PS    = 1;
    localparam int M_LOCK  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic [3:0]  led;
    logic [63:0] o = 64'd0;
    logic [63:0] t = 64'd0;
    logic [63:0] gi;
    logic        owner;

    int n_assert = 0;
    int n_fail   = 0;

    emio_led_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_DIV      (BDIV),
        .HB_TIMEOUT     (HBT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .led        (led),
        .emio_gpio_o(o),
        .emio_gpio_t(t),
        .emio_gpio_i(gi),
        .ps_owner   (owner)
    );

    always #5 clk = ~clk;

    // Reference model: state after each rising edge, outputs one edge behind.
    int          m_n;
    int          m_mode;
    int          m_last;
    logic [3:0]  m_deb;
    logic [3:0]  m_evt;
    logic [3:0]  m_ack_prev;
    logic        m_flag;
    logic        m_hb_prev;
    logic [3:0]  hist[$];
    logic [3:0]  exp_led;
    logic [63:0] exp_i;
    logic [63:0] mq;
    int          m_wraps;
    logic [3:0]  m_nd;
    bit          m_same;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_mode = M_LOCAL; m_last = 0;
            m_deb = 4'd0; m_evt = 4'd0; m_ack_prev = 4'd0;
            m_flag = 1'b0; m_hb_prev = 1'b0;
            exp_led = 4'd0; exp_i = 64'd0;
            hist.delete();
            repeat (DEB + 3) hist.push_back(4'd0);
        end else begin
            mq = o & ~t;
            m_wraps = m_n >> BDIV;
            case (m_mode)
                M_LOCAL: exp_led = 4'(1 << (m_wraps % 4)) ^ m_deb;
`ifdef EMIO_LED_PWM_EN
                M_PS:    exp_led = ((m_n % 256) < int'(mq[23:16])) ? mq[3:0] : 4'd0;
`else
                M_PS:    exp_led = mq[3:0];
`endif
                default: exp_led = (m_wraps % 2 == 1) ? 4'b0101 : 4'b1010;
            endcase
            exp_i = {54'd0, m_flag, (m_mode == M_PS), m_evt, m_deb};

            // A debounced bit follows the raw input once it was identical for DEB+1
            // synchronised samples (two-edge synchroniser delay).
            hist.push_back(btn);
            m_nd = m_deb;
            for (int b = 0; b < 4; b++) begin
                m_same = 1'b1;
                for (int k = 2; k <= 2 + DEB; k++)
                    if (hist[hist.size() - 1 - k][b] != hist[hist.size() - 3][b]) m_same = 1'b0;
                if (m_same) m_nd[b] = hist[hist.size() - 3][b];
            end
            m_evt = (m_evt & ~(mq[11:8] & ~m_ack_prev)) | (m_nd & ~m_deb);
            m_deb = m_nd;
            m_ack_prev = mq[11:8];

            case (m_mode)
                M_LOCAL: if (mq[63]) begin m_mode = M_PS; m_last = m_n + 1; end
                M_PS: begin
                    if (!mq[63]) m_mode = M_LOCAL;
                    else if (mq[62] != m_hb_prev) m_last = m_n + 1;
                    else if ((m_n + 1) - m_last >= HBT) begin m_mode = M_LOCK; m_flag = 1'b1; end
                end
                default: if (!mq[63]) begin m_mode = M_LOCAL; m_flag = 1'b0; end
            endcase
            m_hb_prev = mq[62];
            m_n = m_n + 1;
            if (hist.size() > DEB + 8) void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all();
        chk("model_led", 64'(led), 64'(exp_led));
        chk("model_gpio_i", gi, exp_i);
        chk("model_ps_owner", 64'(owner), 64'(m_mode == M_PS));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_all();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int hi_cnt;
    bit found;

    initial begin
        // 1. Reset values, then the walker.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_gpio_i", gi, 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        rst_n = 1'b1;
        step(8);
        chk("walk_0001", 64'(led), 64'h1);
        step(1);
        chk("walk_0010", 64'(led), 64'h2);

        // 2. Debounce with a glitch, then acknowledge the event.
        btn = 4'b0011;
        step(1);
        btn = 4'b0010;
        step(10);
        chk("deb_btn1", 64'(gi[1]), 64'd1);
        chk("deb_evt1", 64'(gi[5]), 64'd1);
        chk("deb_btn0", 64'(gi[0]), 64'd0);
        chk("deb_evt0", 64'(gi[4]), 64'd0);
        o[9] = 1'b1;
        step(3);
        chk("ack_evt1", 64'(gi[5]), 64'd0);
        chk("ack_btn1", 64'(gi[1]), 64'd1);
        o[9] = 1'b0;
        btn = 4'b0000;
        step(10);

        // 3. PS ownership with a live heartbeat.
        o[3:0] = 4'b1100;
        o[63] = 1'b1;
        step(3);
        chk("ps_owner", 64'(owner), 64'd1);
        chk("ps_gpio8", 64'(gi[8]), 64'd1);
`ifndef EMIO_LED_PWM_EN
        chk("ps_led", 64'(led), 64'hC);
`endif
        for (int k = 0; k < 5; k++) begin
            step(8);
            o[62] = ~o[62];
        end
        chk("ps_owner_hb", 64'(owner), 64'd1);
        o[63] = 1'b0;
        step(1);
        chk("ps_release", 64'(owner), 64'd0);

        // 4. Heartbeat stops -> lockout, then release.
        o[63] = 1'b1;
        step(16);
        chk("hb_before_expiry", 64'(owner), 64'd1);
        step(1);
        chk("hb_expired", 64'(owner), 64'd0);
        step(1);
        chk("lock_flag", 64'(gi[9]), 64'd1);
        chk("lock_gpio8", 64'(gi[8]), 64'd0);
        for (int k = 0; k < 16; k++) begin
            step(1);
            chk("lock_pattern", 64'(led == 4'b1010 || led == 4'b0101), 64'd1);
        end
        o[63] = 1'b0;
        step(2);
        chk("lock_flag_clear", 64'(gi[9]), 64'd0);
        chk("lock_owner", 64'(owner), 64'd0);

        // 5. Tristated request and tristated LED bits.
        o[63] = 1'b1;
        t[63] = 1'b1;
        step(5);
        chk("tri_req", 64'(owner), 64'd0);
        t = 64'h0000_0000_0000_000F;
        o[3:0] = 4'b1111;
        step(3);
        chk("tri_led_owner", 64'(owner), 64'd1);
        chk("tri_led", 64'(led), 64'd0);

`ifdef EMIO_LED_PWM_EN
        // 6. PWM duty 0x40, then asynchronous reset while an LED is lit.
        t = 64'd0;
        o[23:16] = 8'h40;
        step(4);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (led == 4'hF) hi_cnt++;
            if (i % 8 == 7) o[62] = ~o[62];
        end
        chk("pwm_duty_64", 64'(hi_cnt), 64'd64);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1);
            if (i % 8 == 7) o[62] = ~o[62];
            if (led == 4'hF) found = 1'b1;
        end
        chk("pwm_found_high", 64'(found), 64'd1);
`else
        // 6. Asynchronous reset while PS drives all LEDs on.
        t = 64'd0;
        step(3);
        chk("pre_rst_led", 64'(led), 64'hF);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 64'(led), 64'd0);
        chk("async_rst_gpio_i", gi, 64'd0);
        chk("async_rst_owner", 64'(owner), 64'd0);
        @(negedge clk);
        o = 64'd0;
        t = 64'd0;
        rst_n = 1'b1;
        step(4);

        // 7. Randomised traffic with a mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) btn = 4'($urandom);
            if ($urandom_range(39) == 0) o[63] = ~o[63];
            if (((c / 64) % 2 == 0) && $urandom_range(5) == 0) o[62] = ~o[62];
            o[3:0] = 4'($urandom);
            o[11:8] = 4'($urandom) & 4'($urandom);
            o[23:16] = 8'($urandom);
            t = ($urandom_range(9) == 0) ? {$urandom, $urandom} : 64'd0;
            step(1);
            if (c == 300) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_rst_led", 64'(led), 64'd0);
                chk("rand_rst_gpio_i", gi, 64'd0);
                @(negedge clk);
                btn = 4'd0;
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
